cordic_test_sequencer: RTL and testbench
========================================

// Module: cordic_test_sequencer
// PURPOSE
//  Run controller for the CORDIC test wrapper. Latches a test configuration on i_start and drives the wrapper's
//  enable, reset, mode, bypass and stop-code inputs. Counts the wrapper's output-valid pulses, captures the last
//  output word as the run signature and compares it with a golden value. Reports pass/fail/timeout, so one
//  scan/host write launches a whole self-test run.
// PARAMETERS
//  DATA_WIDTH        56  width of wrapper data output / golden signature
//  INPUT_DATA_WIDTH  49  width of stop code
//  CNT_W             16  width of cycle timeout and valid counters
//  RST_CYCLES        4   cycles o_wr_rst held high (>=2, covers wrapper reset synchronizer)
// PORTS
//  i_clk           in   1                 clock
//  i_rst           in   1                 synchronous reset, active-high
//  i_start         in   1                 launch request; sampled only in IDLE/DONE
//  i_mode          in   2                 wrapper mode, latched on start
//  i_bypass        in   3                 wrapper bypass, latched on start
//  i_stop_code     in   INPUT_DATA_WIDTH  stop code, latched on start
//  i_vld_target    in   CNT_W             valid pulses that end a run (0 treated as 1)
//  i_timeout       in   CNT_W             max RUN cycles; 0 = no timeout
//  i_golden        in   DATA_WIDTH        expected signature
//  o_wr_en         out  1                 to wrapper i_en
//  o_wr_rst        out  1                 to wrapper i_async_rst
//  o_wr_mode       out  2                 to wrapper i_mode
//  o_wr_bypass     out  3                 to wrapper i_bypass
//  o_wr_stop_code  out  INPUT_DATA_WIDTH  to wrapper i_stop_code
//  i_wr_vld        in   1                 from wrapper o_vld
//  i_wr_data       in   DATA_WIDTH        from wrapper o_data
//  o_busy          out  1                 high in RESET/RUN/CHECK
//  o_done          out  1                 one-cycle pulse on entering DONE
//  o_pass          out  1                 signature==golden and no timeout; held until next start
//  o_timeout       out  1                 run ended by timeout; held until next start
//  o_sig           out  DATA_WIDTH        last captured wrapper word; held until next start
//  o_vld_cnt       out  CNT_W             valid pulses counted in last run (saturating)
// BEHAVIOUR
//  - Reset: state IDLE; all outputs 0 except o_wr_rst=1 (wrapper held in reset while idle).
//  - FSM IDLE -> RESET -> RUN -> CHECK -> DONE; DONE -> RESET on i_start, else stays DONE.
//  - IDLE/DONE + i_start: latch cfg into shadow regs, clear o_sig/o_vld_cnt/o_pass/o_timeout.
//    Next cycle enters RESET. o_wr_mode/bypass/stop_code always come from the shadow regs.
//  - RESET: o_wr_en=1, o_wr_rst=1 for exactly RST_CYCLES cycles; then RUN.
//  - RUN: o_wr_en=1, o_wr_rst=0; cycle counter increments each cycle. Each i_wr_vld: o_sig<=i_wr_data,
//    o_vld_cnt+1 (saturates at all-ones). Exit to CHECK in the cycle the count reaches target, or when
//    cycle count == i_timeout (i_timeout!=0). If both occur in the same cycle, the count wins (o_timeout=0).
//  - CHECK (1 cycle): o_wr_en=0 (freezes wrapper); o_pass <= !timeout && (o_sig==i_golden).
//    i_wr_vld is ignored from CHECK on.
//  - DONE: o_done=1 for the first cycle only; o_wr_en=0; o_wr_rst=0 so the wrapper state stays visible.
//  - i_start in RESET/RUN/CHECK is ignored. i_rst mid-run aborts to IDLE with reset values; no o_done.
//  - Min latency start->o_done = 1 + RST_CYCLES + (RUN cycles) + 2.
// STRUCTURE
//  - cordic_wrapper_pkg: typedef enum logic[2:0] e_seq_state {IDLE,RESET,RUN,CHECK,DONE}.
//  - cordic_wrapper_pkg: struct st_seq_cfg {mode, bypass, stop_code, vld_target, timeout}.
//  - One sub-module, seq_sat_counter: CNT_W saturating counter with clr and inc.
//    Used for cycles, valid pulses and reset length.
// TESTING
//  1 RST_CYCLES=4, start, target=3, wr_vld on RUN cycles 2,5,9 with data 0x1,0x2,0xABC, golden=0xABC
//    -> o_wr_rst high 4 cyc, o_vld_cnt=3, o_sig=0xABC, o_pass=1, o_done 1-cycle pulse.
//  2 Same run, golden=0xABD -> o_pass=0, o_timeout=0.
//  3 target=5, timeout=20, only 2 valids -> exits RUN after 20 cycles, o_timeout=1, o_pass=0, o_vld_cnt=2.
//  4 target=1, timeout=7, valid exactly on RUN cycle 7 -> o_timeout=0; o_pass reflects compare.
//  5 i_start pulsed in RUN, then i_rst at RUN cycle 3 -> start ignored; next cycle IDLE, o_wr_rst=1,
//    all results 0, no o_done.
//  6 mode=2'b11, bypass=3'b010 latched, inputs then changed during RUN -> o_wr_mode/o_wr_bypass stay
//    2'b11/3'b010 until the next start.

Source files
------------

// File: rtl/cordic_wrapper_pkg.sv
// Shared types and defaults for the CORDIC test-wrapper run sequencer.
package cordic_wrapper_pkg;

    localparam int unsigned SEQ_DATA_W = 56;
    localparam int unsigned SEQ_STOP_W = 49;
    localparam int unsigned SEQ_CNT_W  = 16;

    typedef enum logic [2:0] {
        IDLE,
        RESET,
        RUN,
        CHECK,
        DONE
    } e_seq_state;

    // Shadow copy of the run configuration, captured on start
    typedef struct packed {
        logic [1:0]            mode;
        logic [2:0]            bypass;
        logic [SEQ_STOP_W-1:0] stop_code;
        logic [SEQ_CNT_W-1:0]  vld_target;
        logic [SEQ_CNT_W-1:0]  timeout;
    } st_seq_cfg;

    // A zero target would never be reached, so it behaves as a target of one
    function automatic logic [SEQ_CNT_W-1:0] eff_target(input logic [SEQ_CNT_W-1:0] t);
        return (t == '0) ? SEQ_CNT_W'(1) : t;
    endfunction

endpackage

// File: rtl/cordic_test_sequencer_if.sv
// Control/observation bundle between the sequencer (master) and the CORDIC wrapper (slave).
interface cordic_test_sequencer_if
    import cordic_wrapper_pkg::*;
#(
    parameter int unsigned DATA_WIDTH       = SEQ_DATA_W,
    parameter int unsigned INPUT_DATA_WIDTH = SEQ_STOP_W
);

    logic                        wr_en;
    logic                        wr_rst;
    logic [1:0]                  wr_mode;
    logic [2:0]                  wr_bypass;
    logic [INPUT_DATA_WIDTH-1:0] wr_stop_code;
    logic                        wr_vld;
    logic [DATA_WIDTH-1:0]       wr_data;

    modport master (
        output wr_en, wr_rst, wr_mode, wr_bypass, wr_stop_code,
        input  wr_vld, wr_data
    );

    modport slave (
        input  wr_en, wr_rst, wr_mode, wr_bypass, wr_stop_code,
        output wr_vld, wr_data
    );

endinterface

// File: rtl/seq_sat_counter.sv
// Saturating up-counter with synchronous clear; sticks at all-ones.
module seq_sat_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Next count: clear has priority, increment stops at all-ones
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Count register with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/cordic_test_sequencer.sv
// Run controller for the CORDIC test wrapper: latches a configuration on start, sequences the
// wrapper through reset and run, captures the last output word and checks it against a golden.
module cordic_test_sequencer
    import cordic_wrapper_pkg::*;
#(
    parameter int unsigned DATA_WIDTH       = SEQ_DATA_W,
    parameter int unsigned INPUT_DATA_WIDTH = SEQ_STOP_W,
    parameter int unsigned CNT_W            = SEQ_CNT_W,
    parameter int unsigned RST_CYCLES       = 4
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_start,
    input  logic [1:0]                  i_mode,
    input  logic [2:0]                  i_bypass,
    input  logic [INPUT_DATA_WIDTH-1:0] i_stop_code,
    input  logic [CNT_W-1:0]            i_vld_target,
    input  logic [CNT_W-1:0]            i_timeout,
    input  logic [DATA_WIDTH-1:0]       i_golden,
    cordic_test_sequencer_if.master     wr_io,
    output logic                        o_busy,
    output logic                        o_done,
    output logic                        o_pass,
    output logic                        o_timeout,
    output logic [DATA_WIDTH-1:0]       o_sig,
    output logic [CNT_W-1:0]            o_vld_cnt
);

    localparam logic [CNT_W-1:0] RstLast = CNT_W'(RST_CYCLES - 1);

    e_seq_state            state_q, state_d;
    st_seq_cfg             cfg_q, cfg_d;
    logic [DATA_WIDTH-1:0] sig_q, sig_d;
    logic                  pass_q, pass_d;
    logic                  timeout_q, timeout_d;
    logic                  done_q, done_d;

    logic                  start_acc;
    logic [CNT_W-1:0]      rst_cnt, cyc_cnt, vld_cnt;
    logic [CNT_W-1:0]      run_cycle, vld_next;
    logic                  count_hit, time_hit;

    // Start is only honoured while the wrapper is not being exercised
    assign start_acc = i_start && ((state_q == IDLE) || (state_q == DONE));

    seq_sat_counter #(.CNT_W(CNT_W)) u_rst_cnt (
        .clk_i (i_clk),
        .rst_i (i_rst),
        .clr_i (start_acc),
        .inc_i (state_q == RESET),
        .cnt_o (rst_cnt)
    );

    seq_sat_counter #(.CNT_W(CNT_W)) u_cyc_cnt (
        .clk_i (i_clk),
        .rst_i (i_rst),
        .clr_i (start_acc),
        .inc_i (state_q == RUN),
        .cnt_o (cyc_cnt)
    );

    seq_sat_counter #(.CNT_W(CNT_W)) u_vld_cnt (
        .clk_i (i_clk),
        .rst_i (i_rst),
        .clr_i (start_acc),
        .inc_i ((state_q == RUN) && wr_io.wr_vld),
        .cnt_o (vld_cnt)
    );

    // 1-based index of the current RUN cycle and the valid count including this cycle's pulse
    always_comb begin
        run_cycle = cyc_cnt + CNT_W'(1);
        vld_next  = vld_cnt + CNT_W'(1);
        count_hit = (state_q == RUN) && wr_io.wr_vld && (vld_next == eff_target(cfg_q.vld_target));
        time_hit  = (state_q == RUN) && (cfg_q.timeout != '0) && (run_cycle == cfg_q.timeout);
    end

    // Next-state and result-register logic
    always_comb begin
        state_d   = state_q;
        cfg_d     = cfg_q;
        sig_d     = sig_q;
        pass_d    = pass_q;
        timeout_d = timeout_q;
        done_d    = 1'b0;
        unique case (state_q)
            IDLE, DONE: begin
                if (i_start) begin
                    cfg_d.mode       = i_mode;
                    cfg_d.bypass     = i_bypass;
                    cfg_d.stop_code  = i_stop_code;
                    cfg_d.vld_target = i_vld_target;
                    cfg_d.timeout    = i_timeout;
                    sig_d            = '0;
                    pass_d           = 1'b0;
                    timeout_d        = 1'b0;
                    state_d          = RESET;
                end
            end
            RESET: begin
                if (rst_cnt == RstLast) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (wr_io.wr_vld) begin
                    sig_d = wr_io.wr_data;
                end
                // Reaching the target in the timeout cycle still counts as a clean finish
                if (count_hit) begin
                    state_d = CHECK;
                end else if (time_hit) begin
                    state_d   = CHECK;
                    timeout_d = 1'b1;
                end
            end
            CHECK: begin
                pass_d  = !timeout_q && (sig_q == i_golden);
                done_d  = 1'b1;
                state_d = DONE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and result registers with synchronous reset
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= IDLE;
            cfg_q     <= '0;
            sig_q     <= '0;
            pass_q    <= 1'b0;
            timeout_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cfg_q     <= cfg_d;
            sig_q     <= sig_d;
            pass_q    <= pass_d;
            timeout_q <= timeout_d;
            done_q    <= done_d;
        end
    end

    // Wrapper held in reset while idle; left out of reset in DONE so its state stays observable
    assign wr_io.wr_en        = (state_q == RESET) || (state_q == RUN);
    assign wr_io.wr_rst       = (state_q == IDLE) || (state_q == RESET);
    assign wr_io.wr_mode      = cfg_q.mode;
    assign wr_io.wr_bypass    = cfg_q.bypass;
    assign wr_io.wr_stop_code = cfg_q.stop_code;

    assign o_busy    = (state_q == RESET) || (state_q == RUN) || (state_q == CHECK);
    assign o_done    = done_q;
    assign o_pass    = pass_q;
    assign o_timeout = timeout_q;
    assign o_sig     = sig_q;
    assign o_vld_cnt = vld_cnt;

endmodule

// File: tb/tb_cordic_test_sequencer.sv
// Directed bench for cordic_test_sequencer: outputs sampled on the falling edge.
module tb_cordic_test_sequencer;

    logic        clk = 1'b0;
    logic        i_rst;
    logic        i_start;
    logic [1:0]  i_mode;
    logic [2:0]  i_bypass;
    logic [48:0] i_stop_code;
    logic [15:0] i_vld_target;
    logic [15:0] i_timeout;
    logic [55:0] i_golden;
    logic        o_busy, o_done, o_pass, o_timeout;
    logic [55:0] o_sig;
    logic [15:0] o_vld_cnt;

    int tests = 0;
    int fails = 0;

    int   rst_len, run_len, done_len, done_seen;
    logic cleared;

    cordic_test_sequencer_if #(.DATA_WIDTH(56), .INPUT_DATA_WIDTH(49)) wr_if ();

    cordic_test_sequencer #(
        .DATA_WIDTH       (56),
        .INPUT_DATA_WIDTH (49),
        .CNT_W            (16),
        .RST_CYCLES       (4)
    ) dut (
        .i_clk        (clk),
        .i_rst        (i_rst),
        .i_start      (i_start),
        .i_mode       (i_mode),
        .i_bypass     (i_bypass),
        .i_stop_code  (i_stop_code),
        .i_vld_target (i_vld_target),
        .i_timeout    (i_timeout),
        .i_golden     (i_golden),
        .wr_io        (wr_if.master),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_pass       (o_pass),
        .o_timeout    (o_timeout),
        .o_sig        (o_sig),
        .o_vld_cnt    (o_vld_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Launch a run, drive up to three valid pulses on given 1-based RUN cycles, then
    // offer stray valids in CHECK/DONE and count o_done pulses. Ends in DONE.
    task automatic run_test(input int c1, input logic [55:0] d1,
                            input int c2, input logic [55:0] d2,
                            input int c3, input logic [55:0] d3,
                            output int rlen, output int nlen, output int dlen,
                            output logic clr);
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        clr = !o_pass && !o_timeout && (o_sig == '0) && (o_vld_cnt == '0);
        rlen = 0;
        while (wr_if.wr_rst && wr_if.wr_en && rlen < 64) begin
            rlen++;
            @(negedge clk);
        end
        nlen = 0;
        while (wr_if.wr_en && !wr_if.wr_rst && nlen < 256) begin
            nlen++;
            wr_if.wr_vld  = (nlen == c1) || (nlen == c2) || (nlen == c3);
            wr_if.wr_data = (nlen == c1) ? d1 : (nlen == c2) ? d2 : (nlen == c3) ? d3 : 56'hBAD;
            @(negedge clk);
        end
        wr_if.wr_vld  = 1'b1;
        wr_if.wr_data = 56'hDEAD;
        dlen = 0;
        for (int i = 0; i < 4; i++) begin
            if (o_done) dlen++;
            @(negedge clk);
        end
        wr_if.wr_vld = 1'b0;
    endtask

    initial begin
        i_rst         = 1'b1;
        i_start       = 1'b0;
        i_mode        = 2'b00;
        i_bypass      = 3'b000;
        i_stop_code   = '0;
        i_vld_target  = 16'd3;
        i_timeout     = 16'd0;
        i_golden      = 56'hABC;
        wr_if.wr_vld  = 1'b0;
        wr_if.wr_data = '0;
        repeat (2) @(negedge clk);
        i_rst = 1'b0;
        @(negedge clk);

        // Reset / idle state
        check("rst_wr_rst", 64'(wr_if.wr_rst), 64'h1);
        check("rst_wr_en", 64'(wr_if.wr_en), 64'h0);
        check("rst_busy", 64'(o_busy), 64'h0);
        check("rst_done", 64'(o_done), 64'h0);
        check("rst_pass", 64'(o_pass), 64'h0);
        check("rst_sig", 64'(o_sig), 64'h0);
        check("rst_vld_cnt", 64'(o_vld_cnt), 64'h0);

        // 1: target 3, valids on RUN cycles 2,5,9, golden matches
        run_test(2, 56'h1, 5, 56'h2, 9, 56'hABC, rst_len, run_len, done_len, cleared);
        check("t1_rst_len", 64'(rst_len), 64'd4);
        check("t1_run_len", 64'(run_len), 64'd9);
        check("t1_done_pulse", 64'(done_len), 64'd1);
        check("t1_vld_cnt", 64'(o_vld_cnt), 64'd3);
        check("t1_sig", 64'(o_sig), 64'hABC);
        check("t1_pass", 64'(o_pass), 64'h1);
        check("t1_timeout", 64'(o_timeout), 64'h0);
        check("t1_done_wr_rst", 64'(wr_if.wr_rst), 64'h0);
        check("t1_done_wr_en", 64'(wr_if.wr_en), 64'h0);
        check("t1_done_busy", 64'(o_busy), 64'h0);

        // 2: same run, golden off by one
        i_golden = 56'hABD;
        run_test(2, 56'h1, 5, 56'h2, 9, 56'hABC, rst_len, run_len, done_len, cleared);
        check("t2_cleared_on_start", 64'(cleared), 64'h1);
        check("t2_pass", 64'(o_pass), 64'h0);
        check("t2_timeout", 64'(o_timeout), 64'h0);
        check("t2_sig", 64'(o_sig), 64'hABC);

        // 3: timeout 20 with only two valids; golden matches but timeout forbids pass
        i_vld_target = 16'd5;
        i_timeout    = 16'd20;
        i_golden     = 56'h22;
        run_test(3, 56'h11, 10, 56'h22, 0, 56'h0, rst_len, run_len, done_len, cleared);
        check("t3_run_len", 64'(run_len), 64'd20);
        check("t3_timeout", 64'(o_timeout), 64'h1);
        check("t3_pass", 64'(o_pass), 64'h0);
        check("t3_vld_cnt", 64'(o_vld_cnt), 64'd2);
        check("t3_sig", 64'(o_sig), 64'h22);

        // 4: target reached in the same cycle as the timeout
        i_vld_target = 16'd1;
        i_timeout    = 16'd7;
        i_golden     = 56'h77;
        run_test(7, 56'h77, 0, 56'h0, 0, 56'h0, rst_len, run_len, done_len, cleared);
        check("t4_run_len", 64'(run_len), 64'd7);
        check("t4_timeout", 64'(o_timeout), 64'h0);
        check("t4_pass", 64'(o_pass), 64'h1);
        check("t4_vld_cnt", 64'(o_vld_cnt), 64'd1);

        // Target 0 behaves as 1
        i_vld_target = 16'd0;
        i_timeout    = 16'd0;
        run_test(2, 56'h5, 0, 56'h0, 0, 56'h0, rst_len, run_len, done_len, cleared);
        check("t4b_run_len", 64'(run_len), 64'd2);
        check("t4b_vld_cnt", 64'(o_vld_cnt), 64'd1);

        // 6: configuration latched on start, live inputs changed afterwards
        i_mode       = 2'b11;
        i_bypass     = 3'b010;
        i_stop_code  = 49'h1_2345_6789_ABCD;
        i_vld_target = 16'd1;
        i_timeout    = 16'd0;
        i_start      = 1'b1;
        @(negedge clk);
        i_start      = 1'b0;
        i_mode       = 2'b00;
        i_bypass     = 3'b101;
        i_stop_code  = '0;
        i_vld_target = 16'd9;
        i_timeout    = 16'd3;
        repeat (5) @(negedge clk);
        check("t6_run_wr_en", 64'(wr_if.wr_en), 64'h1);
        check("t6_run_mode", 64'(wr_if.wr_mode), 64'h3);
        check("t6_run_bypass", 64'(wr_if.wr_bypass), 64'h2);
        check("t6_run_stop", 64'(wr_if.wr_stop_code), 64'h1_2345_6789_ABCD);
        repeat (3) @(negedge clk);
        check("t6_timeout_latched", 64'(wr_if.wr_en), 64'h1);
        wr_if.wr_vld  = 1'b1;
        wr_if.wr_data = 56'h66;
        @(negedge clk);
        wr_if.wr_vld = 1'b0;
        @(negedge clk);
        check("t6_done", 64'(o_done), 64'h1);
        check("t6_target_latched", 64'(o_vld_cnt), 64'd1);
        check("t6_done_mode", 64'(wr_if.wr_mode), 64'h3);
        check("t6_done_bypass", 64'(wr_if.wr_bypass), 64'h2);

        // 5: next start picks up new config; start in RUN ignored; reset mid-run aborts
        i_vld_target = 16'd5;
        i_timeout    = 16'd0;
        i_start      = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        check("t5_new_mode", 64'(wr_if.wr_mode), 64'h0);
        check("t5_new_bypass", 64'(wr_if.wr_bypass), 64'h5);
        repeat (4) @(negedge clk);
        i_start       = 1'b1;
        wr_if.wr_vld  = 1'b1;
        wr_if.wr_data = 56'h55;
        @(negedge clk);
        i_start      = 1'b0;
        wr_if.wr_vld = 1'b0;
        check("t5_start_ignored_rst", 64'(wr_if.wr_rst), 64'h0);
        check("t5_start_ignored_en", 64'(wr_if.wr_en), 64'h1);
        check("t5_run_sig", 64'(o_sig), 64'h55);
        @(negedge clk);
        i_rst = 1'b1;
        @(negedge clk);
        i_rst = 1'b0;
        done_seen = 0;
        if (o_done) done_seen++;
        check("t5_wr_rst", 64'(wr_if.wr_rst), 64'h1);
        check("t5_wr_en", 64'(wr_if.wr_en), 64'h0);
        check("t5_busy", 64'(o_busy), 64'h0);
        check("t5_pass", 64'(o_pass), 64'h0);
        check("t5_timeout", 64'(o_timeout), 64'h0);
        check("t5_sig", 64'(o_sig), 64'h0);
        check("t5_vld_cnt", 64'(o_vld_cnt), 64'h0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (o_done) done_seen++;
        end
        check("t5_no_done", 64'(done_seen), 64'd0);
        check("t5_stays_idle", 64'(o_busy), 64'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
